// File: rtl/jtframe_sdram64_pkg.sv
// Shared definitions for the 64-bit SDRAM controller data path: bank count,
// burst geometry and write FSM encodings.
package jtframe_sdram64_pkg;

    localparam int NBANK = 4;
    localparam int BANKW = 2;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_MASK = 2'd2
    } wr_state_t;

    typedef struct packed {
        logic             valid;
        logic [BANKW-1:0] bank;
    } dly_entry_t;

    // Number of 16-bit DQ words in one burst
    function automatic int dticks(input int burstlen);
        return burstlen / 16;
    endfunction

endpackage

// File: rtl/jtframe_sdram64_dly.sv
// Fixed-latency delay line carrying {valid, bank} from a read start to the
// cycle its first data word appears on DQ.
module jtframe_sdram64_dly
    import jtframe_sdram64_pkg::*;
#(
    parameter int DLY = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [BANKW-1:0] in_bank,
    output logic             out_valid,
    output logic [BANKW-1:0] out_bank,
    output logic [DLY-1:0]   stage_valid
);

    dly_entry_t pipe [DLY];

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the previous stage's old value on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DLY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: in_valid, bank: in_bank};
            for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign out_valid = pipe[DLY-1].valid;
    assign out_bank  = pipe[DLY-1].bank;

    always_comb begin
        for (int i = 0; i < DLY; i++) stage_valid[i] = pipe[i].valid;
    end

endmodule

// File: rtl/jtframe_sdram64_dq.sv
// SDRAM DQ/DQM data path: drives write bursts, assembles read bursts into a
// 64-bit word and flags bus-sharing violations from the bank sequencers.
module jtframe_sdram64_dq
    import jtframe_sdram64_pkg::*;
#(
    parameter int BURSTLEN = 64,
    parameter int DLY      = 2
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NBANK-1:0] dst,
    input  logic [NBANK-1:0] wr,
    input  logic [15:0]      din,
    input  logic [1:0]       din_m,
    input  logic [15:0]      dq_in,
    output logic [15:0]      dq_out,
    output logic             dq_oe,
    output logic [1:0]       dqm,
    output logic [63:0]      dout,
    output logic [NBANK-1:0] ok,
    output logic             rd_busy,
    output logic             err
);

    localparam int         DTICKS = dticks(BURSTLEN);
    localparam logic [1:0] LAST   = 2'(DTICKS - 1);

    // Delay-line stages whose read data would share DQ with a write starting now
    function automatic logic [DLY-1:0] col_mask_f();
        logic [DLY-1:0] m;
        m = '0;
        for (int s = 0; s < DLY; s++)
            m[s] = ((DLY - 1 - s) <= DTICKS) && ((DLY - 2 - s + DTICKS) >= 1);
        return m;
    endfunction

    localparam logic [DLY-1:0] COL_MASK = col_mask_f();

    // ---------------- start decode ----------------
    logic [BANKW-1:0] st_bank;
    logic             st_any, st_multi, wr_start, rd_start;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        st_bank = '0;
        for (int i = NBANK - 1; i >= 0; i--)
            if (dst[i]) st_bank = BANKW'(i);
        st_any   = |dst;
        st_multi = |(dst & (dst - {{(NBANK-1){1'b0}}, 1'b1}));
        wr_start = st_any & wr[st_bank];
        rd_start = st_any & ~wr[st_bank];
    end

    // ---------------- write FSM ----------------
    wr_state_t   wst, wst_nx;
    logic [1:0]  mcnt, mcnt_nx;
    logic [15:0] dq_out_nx;
    logic [1:0]  dqm_nx;
    logic        oe_nx;

    always_comb begin
        wst_nx    = wst;
        mcnt_nx   = mcnt;
        dq_out_nx = dq_out;
        dqm_nx    = dqm;
        oe_nx     = dq_oe;
        if (wr_start) begin
            wst_nx    = W_DATA;
            dq_out_nx = din;
            dqm_nx    = ~din_m;
            oe_nx     = 1'b1;
        end else begin
            unique case (wst)
                W_IDLE: ;
                W_DATA: begin
                    if (DTICKS > 1) begin
                        wst_nx  = W_MASK;
                        dqm_nx  = 2'b11;
                        mcnt_nx = 2'(DTICKS - 2);
                    end else begin
                        wst_nx = W_IDLE;
                        dqm_nx = 2'b00;
                        oe_nx  = 1'b0;
                    end
                end
                W_MASK: begin
                    if (mcnt == 2'd0) begin
                        wst_nx = W_IDLE;
                        dqm_nx = 2'b00;
                        oe_nx  = 1'b0;
                    end else begin
                        mcnt_nx = mcnt - 2'd1;
                    end
                end
                default: begin
                    wst_nx = W_IDLE;
                    dqm_nx = 2'b00;
                    oe_nx  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst    <= W_IDLE;
            mcnt   <= 2'd0;
            dq_out <= 16'd0;
            dqm    <= 2'b00;
            dq_oe  <= 1'b0;
        end else begin
            wst    <= wst_nx;
            mcnt   <= mcnt_nx;
            dq_out <= dq_out_nx;
            dqm    <= dqm_nx;
            dq_oe  <= oe_nx;
        end
    end

    // ---------------- read capture ----------------
    logic             ex_valid;
    logic [BANKW-1:0] ex_bank;
    logic [DLY-1:0]   stage_valid;

    jtframe_sdram64_dly #(.DLY(DLY)) u_dly (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (rd_start),
        .in_bank     (st_bank),
        .out_valid   (ex_valid),
        .out_bank    (ex_bank),
        .stage_valid (stage_valid)
    );

    logic             cap_act;
    logic [1:0]       cnt;
    logic [BANKW-1:0] cap_bank;
    logic             cap_now;
    logic [1:0]       slot;
    logic [BANKW-1:0] bank_now;

    // The exit cycle itself samples word 0, so the capture starts without a bubble
    always_comb begin
        cap_now  = ex_valid | cap_act;
        slot     = ex_valid ? 2'd0 : cnt;
        bank_now = ex_valid ? ex_bank : cap_bank;
    end

    // NOTE: dout is an ordinary register, not a memory, so it is reset along
    // with the rest of the state to give a defined value after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout     <= 64'd0;
            ok       <= '0;
            rd_busy  <= 1'b0;
            cap_act  <= 1'b0;
            cnt      <= 2'd0;
            cap_bank <= '0;
        end else begin
            ok      <= '0;
            rd_busy <= cap_now;
            if (cap_now) begin
                dout[{slot, 4'b0000} +: 16] <= dq_in;
                cap_bank <= bank_now;
                if (slot == LAST) begin
                    ok[bank_now] <= 1'b1;
                    cap_act      <= 1'b0;
                end else begin
                    cap_act <= 1'b1;
                    cnt     <= slot + 2'd1;
                end
            end
        end
    end

    // ---------------- protocol errors ----------------
    logic err_set;

    always_comb begin
        err_set = st_multi
                | (wr_start & (wst != W_IDLE))
                | (wr_start & (rd_busy | (|(stage_valid & COL_MASK))))
                | (ex_valid & cap_act);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

endmodule

// File: tb/tb_jtframe_sdram64_dq.sv
// Directed bench for jtframe_sdram64_dq: write timing, read bursts tracked
// through a scoreboard of expected completions, error and reset behaviour.
module tb_jtframe_sdram64_dq;

    localparam int BURSTLEN = 64;
    localparam int DLY      = 2;
    localparam int DTICKS   = BURSTLEN / 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  dst, wr;
    logic [15:0] din;
    logic [1:0]  din_m;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [1:0]  dqm;
    logic [63:0] dout;
    logic [3:0]  ok;
    logic        rd_busy;
    logic        err;

    jtframe_sdram64_dq #(.BURSTLEN(BURSTLEN), .DLY(DLY)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .dst     (dst),
        .wr      (wr),
        .din     (din),
        .din_m   (din_m),
        .dq_in   (dq_in),
        .dq_out  (dq_out),
        .dq_oe   (dq_oe),
        .dqm     (dqm),
        .dout    (dout),
        .ok      (ok),
        .rd_busy (rd_busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          bank;
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sched [int];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_dq_out"},  64'(dq_out),  64'd0);
        check({tag, "_dq_oe"},   64'(dq_oe),   64'd0);
        check({tag, "_dqm"},     64'(dqm),     64'd0);
        check({tag, "_dout"},    dout,         64'd0);
        check({tag, "_ok"},      64'(ok),      64'd0);
        check({tag, "_rd_busy"}, 64'(rd_busy), 64'd0);
        check({tag, "_err"},     64'(err),     64'd0);
    endtask

    // Issue a read start this cycle and schedule its burst on dq_in
    task automatic rd(input logic [3:0] dstv, input int bank, input logic [63:0] data, input bit want_ok);
        exp_t e;
        for (int k = 0; k < DTICKS; k++) sched[cyc + DLY + k] = data[16*k +: 16];
        if (want_ok) begin
            e.bank = bank;
            e.data = data;
            e.at   = cyc + DLY + DTICKS;
            exp_q.push_back(e);
        end
        dst = dstv;
        wr  = 4'b0000;
        tick();
        dst = 4'b0000;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    // dq_in driver: scheduled burst words, random noise elsewhere
    initial forever begin
        @(posedge clk);
        #1;
        dq_in = sched.exists(cyc) ? sched[cyc] : 16'($urandom);
    end

    // Completion monitor: every ok pulse must match the oldest expectation
    initial forever begin
        @(negedge clk);
        if (ok !== 4'b0000) begin
            if (exp_q.size() == 0) begin
                check("ok_unexpected", 64'(ok), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ok_bank",  64'(ok),  64'(4'b0001 << e.bank));
                check("ok_dout",  dout,     e.data);
                check("ok_cycle", 64'(cyc), 64'(e.at));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        dst   = 4'b0000;
        wr    = 4'b0000;
        din   = 16'h0000;
        din_m = 2'b00;

        // Reset state
        repeat (3) tick();
        check_idle("reset");
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Single write: dq driven for DTICKS cycles, first word unmasked
        dst = 4'b0001; wr = 4'b0001; din = 16'hABCD; din_m = 2'b01;
        tick();
        dst = 4'b0000; wr = 4'b0000;
        check("wr_n1_oe",  64'(dq_oe),  64'd1);
        check("wr_n1_dq",  64'(dq_out), 64'hABCD);
        check("wr_n1_dqm", 64'(dqm),    64'd2);
        for (int k = 2; k <= DTICKS; k++) begin
            tick();
            check("wr_mask_oe",  64'(dq_oe),  64'd1);
            check("wr_mask_dqm", 64'(dqm),    64'd3);
            check("wr_mask_dq",  64'(dq_out), 64'hABCD);
        end
        tick();
        check("wr_end_oe",  64'(dq_oe), 64'd0);
        check("wr_end_dqm", 64'(dqm),   64'd0);
        check("wr_err",     64'(err),   64'd0);

        // Single read on bank 2, with rd_busy window N+3..N+6
        rd(4'b0100, 2, 64'h4444_3333_2222_1111, 1'b1);
        for (int t = 1; t <= 7; t++) begin
            check("rd1_busy", 64'(rd_busy), 64'((t >= DLY + 1) && (t <= DLY + DTICKS)));
            tick();
        end
        drain("rd1_drain");
        check("rd1_err", 64'(err), 64'd0);

        // Back-to-back reads: bank 1 at N, bank 3 at N+4
        rd(4'b0010, 1, 64'hA0A3_A0A2_A0A1_A0A0, 1'b1);
        check("b2b_busy_n1", 64'(rd_busy), 64'd0);
        tick();
        check("b2b_busy_n2", 64'(rd_busy), 64'd0);
        tick();
        check("b2b_busy_n3", 64'(rd_busy), 64'd1);
        tick();
        rd(4'b1000, 3, 64'hB0B3_B0B2_B0B1_B0B0, 1'b1);
        for (int t = 5; t <= 10; t++) begin
            check("b2b_busy_run", 64'(rd_busy), 64'd1);
            tick();
        end
        check("b2b_busy_n11", 64'(rd_busy), 64'd0);
        drain("b2b_drain");
        check("b2b_err", 64'(err), 64'd0);

        // Overlapping reads: bank 0 dropped, bank 2 completes at N+8
        rd(4'b0001, 0, 64'hC0C3_C0C2_C0C1_C0C0, 1'b0);
        tick();
        rd(4'b0100, 2, 64'hD0D3_D0D2_D0D1_D0D0, 1'b1);
        drain("ovl_drain");
        check("ovl_err", 64'(err), 64'd1);

        // Reset in the middle of a burst
        rd(4'b0010, 1, 64'hE0E3_E0E2_E0E1_E0E0, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_idle("mid_rst");
        tick();
        rst_n = 1'b1;
        for (int t = 0; t < 6; t++) begin
            check("mid_rst_no_ok", 64'(ok), 64'd0);
            tick();
        end
        rd(4'b0001, 0, 64'h0F0F_1234_5678_9ABC, 1'b1);
        drain("fresh_drain");
        check("fresh_err", 64'(err), 64'd0);

        // Multi-hot start: lowest bank served, error flagged
        rd(4'b0110, 1, 64'h7777_6666_5555_4444, 1'b1);
        drain("multi_drain");
        check("multi_err", 64'(err), 64'd1);

        tick();
        check("final_ok", 64'(ok), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
